clashup_core_p: RTL and testbench
=================================

Name: clashup_core_p

Overview:
Parametrised multi-cycle ClashUp execution core.
- Generalises the 8-bit SET/ADD/OUT core to configurable data width, register count and program memory depth.
- Adds SUB, JMP, JZ, NOP and HALT, a host program-load port, an explicit run/halt lifecycle, illegal-opcode detection and a valid/ready output channel.
- Sits between the ClashUp program loader (host side) and downstream output consumers.

Parameters:
- DW, 8: data/instruction word width; DW >= 8.
- NREG, 8: number of general registers; power of two, >= 2.
- DEPTH, 256: program/data memory words; power of two, <= 2^DW.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- prog_we  input  1  memory write strobe; honoured only in IDLE or HALT.
- prog_addr  input  log2(DEPTH)  memory write address.
- prog_wdata  input  DW  memory write data.
- run  input  1  start pulse; honoured only in IDLE or HALT.
- out_data  output  DW  OUT value.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- halted  output  1  core in HALT state.
- err  output  1  illegal opcode seen; sticky until next run.
- pc_o  output  log2(DEPTH)  current program counter.

Behaviour:
Reset values:
- pc=0, all registers=0, out_data=0, out_valid=0, halted=0, err=0, state=IDLE.
- Memory contents are not reset.
- rst mid-instruction aborts it immediately; a pending out_valid drops with no handshake.

Memory:
- Asynchronous read at pc; synchronous write on prog_we.
- Address operands use the low log2(DEPTH) bits.
- Register operands use the low log2(NREG) bits.

Opcode set (operands occupy the following words):
- 0x00 NOP
- 0x01 SET r,imm
- 0x02 ADD r1,r2 (r1=r1+r2)
- 0x03 OUT r
- 0x04 SUB r1,r2 (r1=r1-r2)
- 0x05 JMP addr
- 0x06 JZ r,addr (branch if r==0)
- 0x07 HALT
- Any other value is illegal.

State machine (one state per cycle):
- IDLE: on run -> FETCH with pc=0 and err=0. prog_we is accepted in the same cycle.
- FETCH: ir=mem[pc], pc=pc+1. Next state is OP1 if the opcode has operands, otherwise EXEC.
- OP1: a=mem[pc], pc+1. Next state is OP2 for two-operand opcodes, else EXEC.
- OP2: b=mem[pc], pc+1 -> EXEC.
- EXEC: perform the operation, then go to FETCH, except:
  - OUT -> OUTW with out_valid=1.
  - HALT -> HALT.
  - Illegal opcode -> err=1 -> HALT.
- OUTW: out_data held stable. When out_valid && out_ready: out_valid=0 -> FETCH. Holds indefinitely otherwise.
- HALT: halted=1. run -> FETCH with pc=0, err=0, halted=0. Registers are retained.

Latencies (run pulse to next FETCH):
- NOP/HALT: 2 cycles.
- OUT: 3 cycles plus handshake wait.
- JMP: 3 cycles.
- SET/ADD/SUB/JZ: 4 cycles.

Arithmetic:
- ADD/SUB wrap modulo 2^DW; no flags.
- Writing one register from itself, e.g. ADD r1,r1, uses the pre-edge value.

PC and jumps:
- pc wraps DEPTH-1 -> 0, including mid-operand fetch.
- A JMP/JZ taken in EXEC loads pc=addr.
- JZ not taken leaves pc at the next instruction.

Ignored inputs:
- run and prog_we are ignored outside IDLE/HALT.

Optional Feature:
CLASHUP_MUL_EN
- Defined: opcode 0x08 MUL r1,r2 is legal. r1 = low DW bits of r1*r2, with 4-cycle latency like ADD.
- Undefined: 0x08 is illegal and sets err, then HALT. No multiplier is synthesised.

Test Plan:
- Program SET r1,5; SET r2,7; ADD r1,r2; OUT r1; HALT, then run. Required: one out_data=12 handshake, then halted=1 and err=0.
- Hold out_ready=0 for 10 cycles during OUT. Required: out_valid=1 and out_data stable for all 10 cycles; exactly one transfer when out_ready rises; the next FETCH follows.
- Program SET r0,3; SET r1,1; loop: SUB r0,r1; OUT r0; JZ r0,end; JMP loop; end: HALT. Required: outputs 2, 1, 0 in order, then halt.
- DW=8, SET r3,0xFF; SET r4,0x02; ADD r3,r4; OUT r3. Required: out_data=0x01. Then SUB of 0x00-0x01 yields 0xFF.
- Opcode 0x09, and 0x08 when the macro is undefined. Required: err=1 and halted=1 two cycles after run. A subsequent run clears err.
- Assert rst during OUTW. Required: out_valid=0 immediately, state IDLE, registers 0, memory retained; run re-executes the program from pc=0.

Source files
------------

// File: rtl/clashup_core_p.sv
// clashup_core_p: parametrised multi-cycle ClashUp execution core.
// Fetches opcodes and operands from an asynchronously read program memory, executes
// register arithmetic, jumps and OUT transfers over a valid/ready channel, and
// reports HALT and illegal opcodes. Define CLASHUP_MUL_EN to make opcode 0x08 (MUL) legal.
module clashup_core_p #(
  parameter int DW    = 8,
  parameter int NREG  = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DW-1:0]            prog_wdata,
  input  logic                     run,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     halted,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] pc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NREG);

  localparam logic [DW-1:0] OP_NOP  = DW'(0);
  localparam logic [DW-1:0] OP_SET  = DW'(1);
  localparam logic [DW-1:0] OP_ADD  = DW'(2);
  localparam logic [DW-1:0] OP_OUT  = DW'(3);
  localparam logic [DW-1:0] OP_SUB  = DW'(4);
  localparam logic [DW-1:0] OP_JMP  = DW'(5);
  localparam logic [DW-1:0] OP_JZ   = DW'(6);
  localparam logic [DW-1:0] OP_HALT = DW'(7);
`ifdef CLASHUP_MUL_EN
  localparam logic [DW-1:0] OP_MUL  = DW'(8);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OP1, S_OP2, S_EXEC, S_OUTW, S_HALT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] mem_rd;
  logic [RW-1:0] ra;
  logic [RW-1:0] rb;
  logic          loadable;

  // Number of operand words that follow an opcode; illegal opcodes have none.
  function automatic logic [1:0] op_count(input logic [DW-1:0] op);
    logic [1:0] n;
    case (op)
      OP_SET, OP_ADD, OP_SUB, OP_JZ: n = 2'd2;
      OP_OUT, OP_JMP:                n = 2'd1;
`ifdef CLASHUP_MUL_EN
      OP_MUL:                        n = 2'd2;
`endif
      default:                       n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_legal(input logic [DW-1:0] op);
    logic ok;
    ok = (op <= OP_HALT);
`ifdef CLASHUP_MUL_EN
    ok = ok || (op == OP_MUL);
`endif
    return ok;
  endfunction

  // Register arithmetic wraps modulo 2^DW; MUL keeps the low DW bits of the product.
  function automatic logic [DW-1:0] alu_wrap(input logic [DW-1:0] op,
                                             input logic [DW-1:0] x,
                                             input logic [DW-1:0] y);
    logic [DW-1:0] r;
    case (op)
      OP_SUB:  r = x - y;
`ifdef CLASHUP_MUL_EN
      OP_MUL:  r = x * y;
`endif
      default: r = x + y;
    endcase
    return r;
  endfunction

  assign mem_rd    = mem[pc];
  assign ra        = a[RW-1:0];
  assign rb        = b[RW-1:0];
  assign loadable  = (state == S_IDLE) || (state == S_HALT);
  assign out_valid = (state == S_OUTW);
  assign halted    = (state == S_HALT);
  assign pc_o      = pc;

  // Program memory: host writes only while the core is idle or halted; never reset.
  always_ff @(posedge clk) begin
    if (prog_we && loadable) mem[prog_addr] <= prog_wdata;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: one state per cycle, operand states skipped when unused.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (run) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = (op_count(mem_rd) != 2'd0) ? S_OP1 : S_EXEC;
      S_OP1:          state_nxt = (op_count(ir) == 2'd2) ? S_OP2 : S_EXEC;
      S_OP2:          state_nxt = S_EXEC;
      S_EXEC: begin
        if (!is_legal(ir) || ir == OP_HALT) state_nxt = S_HALT;
        else if (ir == OP_OUT)              state_nxt = S_OUTW;
        else                                state_nxt = S_FETCH;
      end
      S_OUTW:         if (out_ready) state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Datapath: pc, instruction/operand latches, register file, OUT value and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      out_data <= '0;
      err      <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            pc  <= '0;
            err <= 1'b0;
          end
        end
        S_FETCH: begin
          ir <= mem_rd;
          pc <= pc + 1'b1;
        end
        S_OP1: begin
          a  <= mem_rd;
          pc <= pc + 1'b1;
        end
        S_OP2: begin
          b  <= mem_rd;
          pc <= pc + 1'b1;
        end
        S_EXEC: begin
          case (ir)
            OP_NOP, OP_HALT: ;
            OP_SET:          regs[ra] <= b;
            OP_ADD, OP_SUB:  regs[ra] <= alu_wrap(ir, regs[ra], regs[rb]);
`ifdef CLASHUP_MUL_EN
            OP_MUL:          regs[ra] <= alu_wrap(ir, regs[ra], regs[rb]);
`endif
            OP_OUT:          out_data <= regs[ra];
            OP_JMP:          pc <= a[AW-1:0];
            OP_JZ:           if (regs[ra] == '0) pc <= b[AW-1:0];
            default:         err <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clashup_core_p.sv
// Testbench for clashup_core_p: scenario tasks with a queue of expected OUT values.
module tb_clashup_core_p;
  localparam int DW    = 8;
  localparam int NREG  = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_wdata;
  logic          run;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          halted;
  logic          err;
  logic [AW-1:0] pc_o;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];

  typedef logic [7:0] word_q_t[$];

  always #5 clk = ~clk;

  clashup_core_p #(.DW(DW), .NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .run(run), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted),
    .err(err), .pc_o(pc_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input word_q_t w);
    for (int i = 0; i < w.size(); i++) begin
      prog_we    = 1'b1;
      prog_addr  = AW'(base + i);
      prog_wdata = w[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Step cycles until halted, comparing every handshake against the expected queue.
  task automatic drain_until_halt(input string name, input int budget);
    int            n;
    logic [DW-1:0] e;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s unexpected_out got=%0h expected=none", name, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            miscompares++;
            $display("FAIL %s out_data got=%0h expected=%0h", name, out_data, e);
          end
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL %s halt_timeout halted=%b expected=1", name, halted);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_outputs got=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s valid_timeout out_valid=%b expected=1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, halted, err} !== 3'b000 || out_data !== 8'h00 || pc_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state got v=%b h=%b e=%b d=%0h pc=%0h expected all 0",
               out_valid, halted, err, out_data, pc_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    load(0, '{8'h01, 8'h01, 8'h05, 8'h01, 8'h02, 8'h07,
              8'h02, 8'h01, 8'h02, 8'h03, 8'h01, 8'h07});
    exp_q.push_back(8'd12);
    pulse_run();
    drain_until_halt("add", 100);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL add_err got=%b expected=0", err);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    pulse_run();
    wait_valid("bp", 100);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        run        = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = 8'd11;
        prog_wdata = 8'h09;
      end
      tick();
      run     = 1'b0;
      prog_we = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd12) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d got v=%b d=%0h expected v=1 d=0c", i, out_valid, out_data);
      end
    end
    vectors++;
    if (pc_o !== 8'd11) begin
      miscompares++;
      $display("FAIL bp_run_ignored pc got=%0h expected=0b", pc_o);
    end
    out_ready = 1'b1;
    exp_q.push_back(8'd12);
    drain_until_halt("bp", 4);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_write_ignored err got=%b expected=0", err);
    end
  endtask

  task automatic test_loop();
    load(0, '{8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 8'h01, 8'h04, 8'h00, 8'h01,
              8'h03, 8'h00, 8'h06, 8'h00, 8'h10, 8'h05, 8'h06, 8'h07});
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    pulse_run();
    drain_until_halt("loop", 300);
  endtask

  task automatic test_wrap();
    load(0, '{8'h01, 8'h03, 8'hFF, 8'h01, 8'h04, 8'h02, 8'h02, 8'h03, 8'h04,
              8'h03, 8'h03, 8'h01, 8'h05, 8'h00, 8'h01, 8'h06, 8'h01,
              8'h04, 8'h05, 8'h06, 8'h03, 8'h05, 8'h07});
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    pulse_run();
    drain_until_halt("wrap", 300);
  endtask

  task automatic test_illegal();
    load(0, '{8'h09});
    pulse_run();
    tick();
    tick();
    vectors++;
    if (halted !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_09 got h=%b e=%b expected h=1 e=1", halted, err);
    end
`ifndef CLASHUP_MUL_EN
    load(0, '{8'h08});
    pulse_run();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_err_clear got=%b expected=0", err);
    end
    tick();
    tick();
    vectors++;
    if (halted !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_08 got h=%b e=%b expected h=1 e=1", halted, err);
    end
`endif
    load(0, '{8'h00, 8'h07});
    pulse_run();
    vectors++;
    if (err !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_rerun got h=%b e=%b expected h=0 e=0", halted, err);
    end
    drain_until_halt("illegal_rerun", 10);
  endtask

  task automatic test_reset_outw();
    load(0, '{8'h01, 8'h02, 8'h2A, 8'h05, 8'hFE});
    load(254, '{8'h03, 8'h02});
    out_ready = 1'b0;
    pulse_run();
    wait_valid("rst_outw", 100);
    vectors++;
    if (out_data !== 8'h2A || pc_o !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_outw_wrap got d=%0h pc=%0h expected d=2a pc=0", out_data, pc_o);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || pc_o !== 8'h00 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_outw_abort got v=%b h=%b pc=%0h d=%0h expected 0", out_valid, halted, pc_o, out_data);
    end
    tick();
    rst = 1'b0;
    pulse_run();
    wait_valid("rst_rerun", 100);
    vectors++;
    if (out_data !== 8'h2A) begin
      miscompares++;
      $display("FAIL rst_mem_retained got=%0h expected=2a", out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(0, '{8'h03, 8'h02, 8'h07});
    out_ready = 1'b1;
    exp_q.push_back(8'h00);
    pulse_run();
    drain_until_halt("rst_regs_zero", 20);
  endtask

  initial begin
    rst        = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    run        = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_add();
    test_backpressure();
    test_loop();
    test_wrap();
    test_illegal();
    test_reset_outw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
